// File: rtl/pipe_pkg.sv
// Shared pipeline constants: Tuse/Tnew encodings, register zero,
// the "no exception" code and the mult/div FSM state type.
package pipe_pkg;
  localparam logic [1:0] T0        = 2'd0;
  localparam logic [1:0] T1        = 2'd1;
  localparam logic [1:0] T2        = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] EXC_NONE  = 5'd31;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: D/E/M hazard info and CP0 decision in,
// stall/freeze/flush and mult/div status out.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 4);
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic             d_is_md;
  logic [4:0]       e_wa;
  logic [1:0]       e_tnew;
  logic [4:0]       m_wa;
  logic [1:0]       m_tnew;
  logic             e_md_start;
  logic             e_md_is_div;
  logic             exc_req;
  logic             stall_fd;
  logic             freeze_e;
  logic             flush_all;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md, e_wa, e_tnew,
           m_wa, m_tnew, e_md_start, e_md_is_div, exc_req,
    input  stall_fd, freeze_e, flush_all, md_busy, md_cnt
  );
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md, e_wa, e_tnew,
           m_wa, m_tnew, e_md_start, e_md_is_div, exc_req,
    output stall_fd, freeze_e, flush_all, md_busy, md_cnt
  );
endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div busy sequencer: loads a cycle count on start and counts down
// to zero; busy while counting. Shared with the HI/LO forwarding logic.
// Build option MD_CANCEL_ON_EXC_EN: an exception aborts a running op.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isDiv,
  input  logic             exc,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);
  md_state_e state;

  assign busy = (state == MD_BUSY);

  // FSM + countdown; a start coinciding with an exception is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !exc) begin
            state <= MD_BUSY;
            cnt   <= isDiv ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          end
        end
        MD_BUSY: begin
`ifdef MD_CANCEL_ON_EXC_EN
          if (exc) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else
`endif
          if (cnt == CNT_W'(1)) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The MD stall keeps a second start out while busy; one here is ignored
  startWhileBusy: assert property (@(posedge clk) disable iff (reset)
    !(start && state == MD_BUSY));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage MIPS hazard/stall scheduler: Tuse/Tnew RAW detection, mult/div
// busy interlock, exception flush priority over every stall.
// Build option MD_CANCEL_ON_EXC_EN (see md_busy_cnt).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  logic             mdBusy;
  logic [CNT_W-1:0] mdCnt;
  logic             rawStall;
  logic             mdStall;
  logic             stall;

  md_busy_cnt #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC),
    .CNT_W   (CNT_W)
  ) uMdCnt (
    .clk  (clk),
    .reset(reset),
    .start(hz.e_md_start),
    .isDiv(hz.e_md_is_div),
    .exc  (hz.exc_req),
    .busy (mdBusy),
    .cnt  (mdCnt)
  );

  // RAW: a producer in E or M whose result lands later than D needs it
  always_comb begin
    rawStall = 1'b0;
    if (hz.d_rs != REG_ZERO && hz.d_tuse_rs != TUSE_NONE) begin
      if (hz.d_rs == hz.e_wa && hz.e_tnew > hz.d_tuse_rs) rawStall = 1'b1;
      if (hz.d_rs == hz.m_wa && hz.m_tnew > hz.d_tuse_rs) rawStall = 1'b1;
    end
    if (hz.d_rt != REG_ZERO && hz.d_tuse_rt != TUSE_NONE) begin
      if (hz.d_rt == hz.e_wa && hz.e_tnew > hz.d_tuse_rt) rawStall = 1'b1;
      if (hz.d_rt == hz.m_wa && hz.m_tnew > hz.d_tuse_rt) rawStall = 1'b1;
    end
  end

  // HI/LO users wait for the md unit, including the cycle it is started
  assign mdStall = hz.d_is_md && (mdBusy || hz.e_md_start);

  // reset > flush > stall
  assign stall        = !reset && !hz.exc_req && (rawStall || mdStall);
  assign hz.stall_fd  = stall;
  assign hz.freeze_e  = stall;
  assign hz.flush_all = !reset && hz.exc_req;
  assign hz.md_busy   = mdBusy;
  assign hz.md_cnt    = mdCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge;
// combinational outputs checked 1ns later, registered state checked on
// the falling edge after the rising edge that updates it.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   nRun  = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif.slave)
  );

  task automatic idleInputs();
    hif.d_rs = 5'd0; hif.d_rt = 5'd0;
    hif.d_tuse_rs = 2'd3; hif.d_tuse_rt = 2'd3;
    hif.d_is_md = 1'b0;
    hif.e_wa = 5'd0; hif.e_tnew = 2'd0;
    hif.m_wa = 5'd0; hif.m_tnew = 2'd0;
    hif.e_md_start = 1'b0; hif.e_md_is_div = 1'b0;
    hif.exc_req = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    hif.d_rs = 5'd1; hif.d_tuse_rs = 2'd0; hif.e_wa = 5'd1; hif.e_tnew = 2'd2;
    cycle(); cycle(); #1;
    nRun++; if (hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL reset_stall got %b want 0", hif.stall_fd); end
    nRun++; if (hif.md_busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", hif.md_busy); end
    nRun++; if (hif.md_cnt !== 4'd0) begin nFail++; $display("FAIL reset_cnt got %0d want 0", hif.md_cnt); end
    hif.exc_req = 1'b1; #1;
    nRun++; if (hif.flush_all !== 1'b0) begin nFail++; $display("FAIL reset_flush got %b want 0", hif.flush_all); end
    idleInputs();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_raw();
    // lw $1 in E, add uses $1 in D next cycle
    idleInputs();
    hif.e_wa = 5'd1; hif.e_tnew = 2'd2; hif.d_rs = 5'd1; hif.d_tuse_rs = 2'd1; #1;
    nRun++; if (hif.stall_fd !== 1'b1 || hif.freeze_e !== 1'b1) begin nFail++; $display("FAIL raw_lw_e got %b%b want 11", hif.stall_fd, hif.freeze_e); end
    cycle();
    // lw now in M with tnew=1, bubble in E
    hif.e_wa = 5'd0; hif.e_tnew = 2'd0; hif.m_wa = 5'd1; hif.m_tnew = 2'd1; #1;
    nRun++; if (hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL raw_lw_m got %b want 0", hif.stall_fd); end
    cycle();
    // rt path through M, tuse 0 < tnew 1
    idleInputs();
    hif.m_wa = 5'd7; hif.m_tnew = 2'd1; hif.d_rt = 5'd7; hif.d_tuse_rt = 2'd0; #1;
    nRun++; if (hif.freeze_e !== 1'b1) begin nFail++; $display("FAIL raw_rt_m got %b want 1", hif.freeze_e); end
    // rt not used
    hif.d_tuse_rt = 2'd3; hif.m_tnew = 2'd3; #1;
    nRun++; if (hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL raw_tuse_none got %b want 0", hif.stall_fd); end
    // address mismatch
    hif.d_tuse_rt = 2'd0; hif.d_rt = 5'd8; #1;
    nRun++; if (hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL raw_mismatch got %b want 0", hif.stall_fd); end
    cycle();
  endtask

  task automatic test_reg_zero();
    idleInputs();
    hif.d_rs = 5'd0; hif.e_wa = 5'd0; hif.e_tnew = 2'd2; hif.d_tuse_rs = 2'd0;
    hif.d_rt = 5'd0; hif.d_tuse_rt = 2'd0; #1;
    nRun++; if (hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL reg_zero got %b want 0", hif.stall_fd); end
    cycle();
  endtask

  task automatic test_mult();
    int stalls;
    idleInputs();
    hif.e_md_start = 1'b1; hif.d_is_md = 1'b1; #1;
    stalls = 0;
    if (hif.stall_fd === 1'b1) stalls++;
    cycle();
    hif.e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      nRun++; if (hif.md_busy !== 1'b1 || hif.md_cnt !== 4'(5 - i)) begin nFail++; $display("FAIL mult_cnt[%0d] got %b/%0d want 1/%0d", i, hif.md_busy, hif.md_cnt, 5 - i); end
      if (hif.stall_fd === 1'b1) stalls++;
      cycle();
    end
    #1;
    nRun++; if (hif.md_busy !== 1'b0 || hif.md_cnt !== 4'd0 || hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL mult_done got %b/%0d/%b want 0/0/0", hif.md_busy, hif.md_cnt, hif.stall_fd); end
    nRun++; if (stalls !== 6) begin nFail++; $display("FAIL mult_stall_cycles got %0d want 6", stalls); end
    idleInputs();
    cycle();
  endtask

  task automatic test_div();
    int busyCyc;
    idleInputs();
    hif.e_md_start = 1'b1; hif.e_md_is_div = 1'b1;
    cycle();
    hif.e_md_start = 1'b0; hif.e_md_is_div = 1'b0;
    busyCyc = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i < 10) begin
        nRun++; if (hif.md_cnt !== 4'(10 - i) || hif.stall_fd !== 1'b0) begin nFail++; $display("FAIL div_cnt[%0d] got %0d/%b want %0d/0", i, hif.md_cnt, hif.stall_fd, 10 - i); end
      end
      if (hif.md_busy === 1'b1) busyCyc++;
      cycle();
    end
    nRun++; if (busyCyc !== 10 || hif.md_cnt !== 4'd0) begin nFail++; $display("FAIL div_busy_cycles got %0d/%0d want 10/0", busyCyc, hif.md_cnt); end
  endtask

  task automatic test_exc_raw();
    idleInputs();
    hif.e_wa = 5'd3; hif.e_tnew = 2'd2; hif.d_rs = 5'd3; hif.d_tuse_rs = 2'd0; #1;
    nRun++; if (hif.stall_fd !== 1'b1 || hif.flush_all !== 1'b0) begin nFail++; $display("FAIL exc_pre got %b/%b want 1/0", hif.stall_fd, hif.flush_all); end
    hif.exc_req = 1'b1; #1;
    nRun++; if (hif.flush_all !== 1'b1 || hif.stall_fd !== 1'b0 || hif.freeze_e !== 1'b0) begin nFail++; $display("FAIL exc_raw got %b/%b/%b want 1/0/0", hif.flush_all, hif.stall_fd, hif.freeze_e); end
    cycle();
    idleInputs();
    cycle();
  endtask

  task automatic test_start_exc();
    idleInputs();
    hif.e_md_start = 1'b1; hif.exc_req = 1'b1;
    cycle();
    idleInputs(); #1;
    nRun++; if (hif.md_busy !== 1'b0 || hif.md_cnt !== 4'd0) begin nFail++; $display("FAIL start_exc got %b/%0d want 0/0", hif.md_busy, hif.md_cnt); end
    cycle();
  endtask

  task automatic test_exc_div();
    idleInputs();
    hif.e_md_start = 1'b1; hif.e_md_is_div = 1'b1;
    cycle();
    idleInputs();
    for (int i = 0; i < 6; i++) cycle();
    #1;
    nRun++; if (hif.md_cnt !== 4'd4) begin nFail++; $display("FAIL exc_div_pre got %0d want 4", hif.md_cnt); end
    hif.exc_req = 1'b1; #1;
    nRun++; if (hif.flush_all !== 1'b1) begin nFail++; $display("FAIL exc_div_flush got %b want 1", hif.flush_all); end
    cycle();
    hif.exc_req = 1'b0; #1;
`ifdef MD_CANCEL_ON_EXC_EN
    nRun++; if (hif.md_busy !== 1'b0 || hif.md_cnt !== 4'd0) begin nFail++; $display("FAIL exc_div_cancel got %b/%0d want 0/0", hif.md_busy, hif.md_cnt); end
`else
    nRun++; if (hif.md_busy !== 1'b1 || hif.md_cnt !== 4'd3) begin nFail++; $display("FAIL exc_div_keep got %b/%0d want 1/3", hif.md_busy, hif.md_cnt); end
    cycle(); cycle(); cycle(); #1;
    nRun++; if (hif.md_busy !== 1'b0 || hif.md_cnt !== 4'd0) begin nFail++; $display("FAIL exc_div_end got %b/%0d want 0/0", hif.md_busy, hif.md_cnt); end
`endif
    cycle();
  endtask

  task automatic test_reset_mid();
    idleInputs();
    hif.e_md_start = 1'b1; hif.e_md_is_div = 1'b1;
    cycle();
    idleInputs();
    cycle(); cycle(); cycle(); #1;
    nRun++; if (hif.md_cnt !== 4'd7) begin nFail++; $display("FAIL rst_mid_pre got %0d want 7", hif.md_cnt); end
    reset = 1'b1;
    cycle(); #1;
    nRun++; if (hif.md_cnt !== 4'd0 || hif.md_busy !== 1'b0) begin nFail++; $display("FAIL rst_mid got %0d/%b want 0/0", hif.md_cnt, hif.md_busy); end
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_reg_zero();
    test_mult();
    test_div();
    test_exc_raw();
    test_start_exc();
    test_exc_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
